// File: rtl/key_char_arbiter_if.sv
// Character handshake bundle between the two sources, the arbiter and the shared sink.
// The master side is the sources and the sink; the slave side is the arbiter.
interface key_char_arbiter_if;
  logic       kbd_valid;
  logic [7:0] kbd_data;
  logic       uart_valid;
  logic [7:0] uart_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_src;
  logic       out_ready;
  logic       kbd_full;
  logic       uart_full;
  logic [7:0] drop_count;

  modport master (
    output kbd_valid, kbd_data, uart_valid, uart_data, out_ready,
    input  out_valid, out_data, out_src, kbd_full, uart_full, drop_count
  );

  modport slave (
    input  kbd_valid, kbd_data, uart_valid, uart_data, out_ready,
    output out_valid, out_data, out_src, kbd_full, uart_full, drop_count
  );
endinterface

// File: rtl/key_char_arbiter.sv
// Two per-source character FIFOs (0=keyboard, 1=UART), drained round-robin into one
// registered valid/ready output stage; overflow drops are counted with saturation.
module key_char_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input logic               clk,
  input logic               reset,
  key_char_arbiter_if.slave s_if
);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LP_FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] LP_PTR_ONE = PTR_W'(1);

  logic [7:0]       r_mem [2][DEPTH];
  logic [PTR_W-1:0] r_wptr [2];
  logic [PTR_W-1:0] r_rptr [2];
  logic [CNT_W-1:0] r_cnt [2];
  logic [1:0]       r_full;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             r_out_src;
  logic             r_last_grant;
  logic [7:0]       r_drop;

  logic [1:0]       w_in_valid;
  logic [7:0]       w_in_data [2];
  logic [1:0]       w_nonempty;
  logic [1:0]       w_at_full;
  logic [1:0]       w_push;
  logic [1:0]       w_ovf;
  logic [1:0]       w_pop;
  logic [CNT_W-1:0] w_cnt_nxt [2];
  logic             w_slot_free;
  logic             w_grant;
  logic             w_pop_any;
  logic [7:0]       w_head;
  logic [8:0]       w_drop_sum;

  always_comb begin
    w_in_valid   = {s_if.uart_valid, s_if.kbd_valid};
    w_in_data[0] = s_if.kbd_data;
    w_in_data[1] = s_if.uart_data;
    for (int s = 0; s < 2; s++) begin
      w_nonempty[s] = (r_cnt[s] != '0);
      w_at_full[s]  = (r_cnt[s] == LP_FULL);
      // NUL bytes are ignored outright; fullness is judged before any same-edge pop.
      w_push[s]     = w_in_valid[s] && (w_in_data[s] != 8'h00) && !w_at_full[s];
      w_ovf[s]      = w_in_valid[s] && (w_in_data[s] != 8'h00) && w_at_full[s];
    end

    w_slot_free = !r_out_valid || s_if.out_ready;
    if (&w_nonempty) w_grant = ~r_last_grant;
    else             w_grant = w_nonempty[1];
    w_pop_any = w_slot_free && (|w_nonempty);
    w_pop     = {w_pop_any && w_grant, w_pop_any && !w_grant};
    w_head    = r_mem[w_grant][r_rptr[w_grant]];

    for (int s = 0; s < 2; s++) begin
      unique case ({w_push[s], w_pop[s]})
        2'b10:   w_cnt_nxt[s] = r_cnt[s] + LP_CNT_ONE;
        2'b01:   w_cnt_nxt[s] = r_cnt[s] - LP_CNT_ONE;
        default: w_cnt_nxt[s] = r_cnt[s];
      endcase
    end

    w_drop_sum = {1'b0, r_drop} + {8'd0, w_ovf[0]} + {8'd0, w_ovf[1]};
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (w_push[s]) r_mem[s][r_wptr[s]] <= w_in_data[s];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        r_wptr[s] <= '0;
        r_rptr[s] <= '0;
        r_cnt[s]  <= '0;
      end
      r_full       <= 2'b00;
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'h00;
      r_out_src    <= 1'b0;
      r_last_grant <= 1'b1;
      r_drop       <= 8'h00;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (w_push[s]) r_wptr[s] <= r_wptr[s] + LP_PTR_ONE;
        if (w_pop[s])  r_rptr[s] <= r_rptr[s] + LP_PTR_ONE;
        r_cnt[s]  <= w_cnt_nxt[s];
        r_full[s] <= (w_cnt_nxt[s] == LP_FULL);
      end
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      if (w_pop_any) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_head;
        r_out_src    <= w_grant;
        r_last_grant <= w_grant;
      end else if (w_slot_free) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign s_if.out_valid  = r_out_valid;
  assign s_if.out_data   = r_out_data;
  assign s_if.out_src    = r_out_src;
  assign s_if.kbd_full   = r_full[0];
  assign s_if.uart_full  = r_full[1];
  assign s_if.drop_count = r_drop;
endmodule

// File: doc/key_char_arbiter.md
Name: key_char_arbiter

Overview:
- Shares one character sink (UART TX or the text-display writer) between two character sources: the PS/2-to-ASCII keyboard path and the UART receive path.
- Each source feeds its own small FIFO.
- A round-robin scheduler drains the two FIFOs into a single registered valid/ready output stage.
- Sits between the keyboard/UART front ends and the shared character consumer.

Parameters:
- DEPTH, 4, entries per source FIFO; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- kbd_valid  in  1  one character offered this cycle (one-cycle pulse from the keyboard ASCII converter).
- kbd_data  in  8  keyboard ASCII code; sampled when kbd_valid=1.
- uart_valid  in  1  one character offered this cycle from the UART receiver.
- uart_data  in  8  UART byte; sampled when uart_valid=1.
- out_valid  out  1  out_data holds a character for the sink.
- out_data  out  8  character to the sink.
- out_src  out  1  origin of out_data: 0=keyboard, 1=UART.
- out_ready  in  1  sink accepts out_data this cycle when out_valid=1.
- kbd_full  out  1  keyboard FIFO holds DEPTH entries.
- uart_full  out  1  UART FIFO holds DEPTH entries.
- drop_count  out  8  characters discarded on FIFO overflow, both sources combined; saturates at 8'hFF.

Behaviour:
- Reset, on a synchronous clk edge with reset=1:
  - Outputs: out_valid=0, out_data=0, out_src=0, kbd_full=0, uart_full=0, drop_count=0.
  - Internal state: both FIFOs empty, all pointers/counters 0, last_grant=1 (UART), so the keyboard wins the first tie.
  - Reset mid-operation discards all queued and held characters; no partial transfer continues.
- Input acceptance:
  - Each cycle with valid=1 is exactly one character. There is no edge detection; the source guarantees pulses.
  - Data 8'h00 is ignored: not stored, not counted as a drop.
  - A push into a full FIFO is discarded and drop_count increments, even if that FIFO is popped the same cycle (fullness is evaluated before the edge).
  - When both sources overflow in the same cycle, drop_count increments by 2, saturating at 8'hFF.
- FIFOs:
  - Circular buffers with PTR_W-bit read/write pointers that wrap modulo DEPTH, plus a count of width PTR_W+1.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - kbd_full and uart_full are registered, derived from the count (count==DEPTH).
- Output stage (one register):
  - "Slot free" means out_valid=0, or out_valid=1 and out_ready=1 this cycle.
  - When the slot is free and at least one FIFO is non-empty, one FIFO is popped and its head is loaded into out_data/out_src; out_valid=1 next cycle.
  - When the slot is free and both FIFOs are empty, out_valid goes to 0 next cycle; out_data and out_src keep their last value.
  - While out_valid=1 and out_ready=0, out_data and out_src are held stable and no FIFO is popped.
  - Back-to-back throughput is one character per cycle while out_ready stays 1 and data is queued.
- Scheduler, round-robin with one-bit last_grant:
  - If both FIFOs are non-empty, grant the source != last_grant.
  - If only one is non-empty, grant it.
  - last_grant updates only on a grant.
- Latency:
  - A character pushed into an empty FIFO on edge E0 is popped on edge E1, with out_valid=1 after E1.
  - The FIFO is not bypassed. Push and pop of the same entry never occur on the same edge.
- Ordering: per-source order is preserved; there is no ordering guarantee across sources.

Test Plan:
- Reset, then kbd_valid pulse with 8'h61, out_ready=1 -> out_valid=1 with out_data=8'h61, out_src=0 exactly two edges after the input cycle; then out_valid=0.
- out_ready=0; push uart 8'h41,8'h42,8'h43,8'h44,8'h45 on consecutive cycles -> first enters the output register, next four fill the FIFO, uart_full=1, no drop; a sixth push 8'h46 -> drop_count=1; with out_ready=1 -> 41,42,43,44,45 in order.
- Preload kbd {31,32,33} and uart {41,42,43}, then out_ready=1 -> sequence 31,41,32,42,33,43 with out_src alternating 0,1,0,1,0,1.
- kbd_valid=1 with kbd_data=8'h00 -> nothing queued, out_valid stays 0, drop_count stays 0.
- Both FIFOs full with out_ready=0; push both sources for 200 cycles -> drop_count saturates at 8'hFF and does not wrap.
- Assert reset while out_valid=1 holding 8'h62 and both FIFOs non-empty -> after the edge: out_valid=0, flags 0, drop_count=0; a new kbd 8'h63 emerges first, with no stale data.
